if_fetch_stage: RTL

//  Instruction-fetch stage feeding the decode stage with pipe_pc/pipe_pc4/pipe_data. Owns the PC, issues
//  in-order requests to instruction memory (variable latency), buffers returns in a fetch queue, applies
//  ID redirects (control_j/pc_j) with flush of queue and in-flight requests, and honours a downstream stall.

---
 rtl/if_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/if_fetch_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// A fetch-queue entry pairs an instruction word with the PC it was fetched from.
package if_pkg;

   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Used for both the in-flight tag FIFO and the fetch queue.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Flush shares the reset path so a redirect empties the queue in one cycle.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order memory requests, buffers
// returns in a fetch queue and feeds the IF/ID register, with redirect and stall.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC,
   parameter int          FQ_DEPTH = 4,
   parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        control_j,
   input  logic [31:0] pc_j,
   input  logic        stall,
   output logic [31:0] pipe_pc,
   output logic [31:0] pipe_pc4,
   output logic [31:0] pipe_data,
   output logic        pipe_valid
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] inflight_nxt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] fq_count;
   logic [CW:0]   credit_used;
   logic [31:0]   tag_pc;
   logic          tag_full;
   logic          tag_empty;
   logic          fq_full;
   logic          fq_empty;
   fq_entry_t     fq_head;
   fq_entry_t     fq_wdata;
   logic          accept;
   logic          ret;
   logic          discard;
   logic          fq_push;
   logic          fq_pop;

   // In-flight count is the tag FIFO occupancy: one tag per accepted, unreturned request.
   assign credit_used  = {1'b0, inflight} + {1'b0, fq_count};
   assign imem_req     = ~reset & ~tag_full & ~fq_full & (credit_used < (CW+1)'(FQ_DEPTH));
   assign imem_addr    = fetch_pc;
   assign accept       = imem_req & imem_ready;
   assign ret          = imem_rvalid & (inflight != '0) & ~tag_empty;
   assign discard      = ret & (control_j | (drop_cnt != '0));
   assign fq_push      = ret & ~discard;
   assign fq_pop       = ~control_j & ~stall & ~fq_empty;
   assign fq_wdata     = '{pc: tag_pc, inst: imem_rdata};
   assign inflight_nxt = inflight + CW'(accept) - CW'(ret);

   fetch_fifo #(
      .WIDTH (32),
      .DEPTH (FQ_DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (ret),
      .flush (1'b0),
      .wdata (fetch_pc),
      .rdata (tag_pc),
      .count (inflight),
      .full  (tag_full),
      .empty (tag_empty)
   );

   fetch_fifo #(
      .WIDTH (64),
      .DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .clk   (clk),
      .reset (reset),
      .push  (fq_push),
      .pop   (fq_pop),
      .flush (control_j),
      .wdata (fq_wdata),
      .rdata (fq_head),
      .count (fq_count),
      .full  (fq_full),
      .empty (fq_empty)
   );

   // Everything still in flight after a redirect belongs to the old stream and is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         if (control_j) begin
            fetch_pc <= {pc_j[31:2], 2'b00};
         end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (control_j) begin
            drop_cnt <= inflight_nxt;
         end else if (ret && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_pc    <= '0;
         pipe_pc4   <= '0;
         pipe_data  <= NOP_INST;
         pipe_valid <= 1'b0;
      end else if (control_j) begin
         pipe_data  <= NOP_INST;
         pipe_valid <= 1'b0;
      end else if (!stall) begin
         if (!fq_empty) begin
            pipe_pc    <= fq_head.pc;
            pipe_pc4   <= fq_head.pc + 32'd4;
            pipe_data  <= fq_head.inst;
            pipe_valid <= 1'b1;
         end else begin
            pipe_data  <= NOP_INST;
            pipe_valid <= 1'b0;
         end
      end
   end

endmodule
